// File: rtl/tx_link_if.sv
// Handshake and encoder-side signals of the transmit link sequencer.
// The slave modport is the sequencer's view; the master modport is the upstream/encoder side.
interface tx_link_if;
  logic [31:0] i_Data;
  logic        i_Valid;
  logic        o_Ready;
  logic [7:0]  o_Enc_Byte;
  logic        o_Enc_K;
  logic        o_Enc_Valid;
  logic [1:0]  o_Enc_RD;
  logic        i_Enc_Unbal;

  modport slave (
    input  i_Data, i_Valid, i_Enc_Unbal,
    output o_Ready, o_Enc_Byte, o_Enc_K, o_Enc_Valid, o_Enc_RD
  );

  modport master (
    output i_Data, i_Valid, i_Enc_Unbal,
    input  o_Ready, o_Enc_Byte, o_Enc_K, o_Enc_Valid, o_Enc_RD
  );
endinterface

// File: rtl/tx_link_sequencer.sv
// 8b/10b transmit link sequencer: comma training, idle commas, byte-serial data
// with bounded comma spacing, and running-disparity ownership.
//
// state | meaning
// OFF   | link disabled, no symbols, RD held negative
// SYNC  | K28.5 training burst of SYNC_COUNT symbols
// IDLE  | link up, K28.5 comma each cycle, ready for a word
// DATA  | serialising the held word, LSB byte first
module tx_link_sequencer #(
  parameter int SYNC_COUNT     = 16,
  parameter int COMMA_INTERVAL = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Link_En,
  tx_link_if.slave   link,
  output logic [1:0] o_State,
  output logic       o_Link_Up
);
  localparam int SW = $clog2(SYNC_COUNT + 1);
  localparam int CW = $clog2(COMMA_INTERVAL + 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COUNT);
  localparam logic [SW-1:0] SYNC_ONE  = SW'(1);
  localparam logic [CW-1:0] WORD_MAX  = CW'(COMMA_INTERVAL);
  localparam logic [CW-1:0] WORD_ONE  = CW'(1);
  localparam logic [7:0]    K28_5     = 8'hBC;
  localparam logic [1:0]    RD_NEG    = 2'b11;
  localparam logic [1:0]    RD_POS    = 2'b01;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_SYNC = 2'b01,
    ST_IDLE = 2'b10,
    ST_DATA = 2'b11
  } state_t;

  state_t        state;
  logic [SW-1:0] sync_cnt;
  logic [CW-1:0] word_cnt;
  logic [1:0]    byte_idx;
  logic [31:0]   word_reg;
  logic [7:0]    enc_byte;
  logic          enc_k;
  logic          enc_valid;
  logic [1:0]    enc_rd;
  logic          accept;

  // Ready is the only output allowed to see i_Link_En combinationally.
  assign link.o_Ready = i_Link_En &&
                        ((state == ST_IDLE) ||
                         (state == ST_DATA && byte_idx == 2'd3 && word_cnt < WORD_MAX));
  assign accept = link.i_Valid && link.o_Ready;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || !i_Link_En) begin
      state     <= ST_OFF;
      sync_cnt  <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      word_reg  <= '0;
      enc_byte  <= '0;
      enc_k     <= 1'b0;
      enc_valid <= 1'b0;
      enc_rd    <= RD_NEG;
    end else begin
      if (enc_valid && link.i_Enc_Unbal)
        enc_rd <= (enc_rd == RD_NEG) ? RD_POS : RD_NEG;
      case (state)
        ST_OFF: begin
          state     <= ST_SYNC;
          sync_cnt  <= SYNC_ONE;
          word_cnt  <= '0;
          enc_valid <= 1'b1;
          enc_k     <= 1'b1;
          enc_byte  <= K28_5;
        end
        ST_SYNC: begin
          word_cnt <= '0;
          if (sync_cnt >= SYNC_LAST)
            state <= ST_IDLE;
          else
            sync_cnt <= sync_cnt + SYNC_ONE;
        end
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_DATA;
            word_reg <= link.i_Data;
            word_cnt <= WORD_ONE;
            byte_idx <= 2'd0;
            enc_byte <= link.i_Data[7:0];
            enc_k    <= 1'b0;
          end else begin
            word_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (byte_idx != 2'd3) begin
            byte_idx <= byte_idx + 2'd1;
            enc_byte <= word_reg[{byte_idx + 2'd1, 3'b000} +: 8];
          end else if (accept) begin
            word_reg <= link.i_Data;
            byte_idx <= 2'd0;
            enc_byte <= link.i_Data[7:0];
            if (word_cnt < WORD_MAX)
              word_cnt <= word_cnt + WORD_ONE;
          end else begin
            state    <= ST_IDLE;
            enc_k    <= 1'b1;
            enc_byte <= K28_5;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign link.o_Enc_Byte  = enc_byte;
  assign link.o_Enc_K     = enc_k;
  assign link.o_Enc_Valid = enc_valid;
  assign link.o_Enc_RD    = enc_rd;
  assign o_State          = state;
  assign o_Link_Up        = state[1];
endmodule

// File: doc/tx_link_sequencer.md
# tx_link_sequencer

Transmit-side link controller that sequences the 8b/10b encoder datapath. It brings the link up with a K28.5 comma training burst, then holds idle commas. It accepts 32-bit words over a valid/ready handshake and feeds them to the encoder one byte per clock, LSB byte first. It owns the running-disparity register that drives the encoder's `i_RD` input, and enforces periodic comma insertion so the receiver keeps word alignment.

## Interface
- `SYNC_COUNT`, default 16: number of K28.5 symbols emitted in training; legal range ≥1.
- `COMMA_INTERVAL`, default 16: maximum number of data words between two comma symbols; legal range ≥1.
- `i_Clk`, input, 1: single clock for the block; all logic is on its rising edge.
- `i_Rst_L`, input, 1: synchronous, active-low reset, sampled on `i_Clk` rising edge.
- `i_Link_En`, input, 1: link enable; low forces OFF.
- `i_Data`, input, 32: upstream data word; byte 0 is `[7:0]`.
- `i_Valid`, input, 1: `i_Data` is valid.
- `o_Ready`, output, 1: word is accepted on a cycle where `i_Valid && o_Ready`.
- `o_Enc_Byte`, output, 8: byte to the encoder (HGF EDCBA).
- `o_Enc_K`, output, 1: 1 means a control symbol (always K28.5, `8'hBC`).
- `o_Enc_Valid`, output, 1: a symbol is presented this cycle.
- `o_Enc_RD`, output, 2 (signed): running disparity to the encoder; `2'sb11` means RD−, `2'sb01` means RD+.
- `i_Enc_Unbal`, input, 1: encoder reports that the current symbol has nonzero disparity. This is same-cycle combinational feedback.
- `o_State`, output, 2: OFF=00, SYNC=01, IDLE=10, DATA=11.
- `o_Link_Up`, output, 1: high in IDLE or DATA.

## Operation
- **States**
  - OFF: `o_Enc_Valid`=0; RD is held at RD−; counters are cleared. If `i_Link_En`=1, go to SYNC.
  - SYNC: emit K28.5 every cycle and count the symbols. After `SYNC_COUNT` symbols, go to IDLE.
  - IDLE: emit K28.5 every cycle, with `o_Ready`=1.
    - On accept: capture `i_Data` in the word register, set the word count to 1, and go to DATA with byte index 0.
  - DATA: emit byte[index] with K=0 and increment the index each cycle.
    - At index 3, `o_Ready` = (word count < `COMMA_INTERVAL`).
    - On accept at index 3: capture the new word, increment the word count, wrap the index to 0, and stay in DATA.
    - Otherwise go to IDLE.
- **Link enable**
  - In any state, `i_Link_En`=0 sends the block to OFF on the next cycle.
  - Unsent bytes of the current word are discarded.
  - `o_Ready` is gated by `i_Link_En`, so no word is accepted on the drop cycle.
  - Re-enabling always repeats the full SYNC burst.
- **Word count**
  - Counts words since the last comma.
  - Cleared in OFF and SYNC.
  - Set to 1 on an IDLE accept, because a comma is emitted that same cycle.
- **Running disparity**
  - On each cycle with `o_Enc_Valid && i_Enc_Unbal`, RD negates (11↔01) on the next edge.
  - `i_Enc_Unbal` is ignored when `o_Enc_Valid`=0.
- **Control symbols**
  - Data byte `8'hBC` with K=0 is D28.5, which is legal and is not treated as a comma.
  - `o_Enc_K`=1 only in SYNC and IDLE.
- **Output timing and widths**
  - All encoder outputs, `o_State` and `o_Link_Up` are functions of registered state only; there is no combinational path from `i_Valid`.
  - `o_Ready` depends on registered state and `i_Link_En`.
  - Counters are `$clog2(SYNC_COUNT+1)` bits and `$clog2(COMMA_INTERVAL+1)` bits wide; they saturate and never wrap.

## Timing
- **Reset** (`i_Rst_L`=0 at an edge) sets:
  - state = OFF, `o_Enc_Valid`=0, `o_Enc_Byte`=0, `o_Enc_K`=0;
  - `o_Enc_RD`=`2'sb11`, `o_Ready`=0, `o_Link_Up`=0, `o_State`=00;
  - all counters and the word register = 0.
  - Reset overrides every other input, including mid-word.
- **Bring-up**
  - `i_Link_En` sampled high at edge 0 puts the block in SYNC from cycle 1.
  - Commas are emitted on cycles 1..`SYNC_COUNT`.
  - IDLE, `o_Link_Up`=1 and `o_Ready`=1 start at cycle `SYNC_COUNT`+1.
- **Data latency**
  - A word accepted in cycle N emits byte0..byte3 on cycles N+1..N+4.
  - The next accept is possible at N+4, giving full throughput of one byte per clock.
- **Comma insertion**
  - After `COMMA_INTERVAL` consecutive words, exactly one comma cycle occurs (IDLE).
  - That comma cycle may itself accept the next word.
- **RD feedback** is visible on `o_Enc_RD` one cycle after the unbalanced symbol.

## Test plan
- Bring-up, `SYNC_COUNT`=4: reset, then `i_Link_En`=1 → 4 cycles of `o_Enc_Byte`=BC with K=1, `o_State`=01; then `o_State`=10, `o_Link_Up`=1, `o_Ready`=1, BC still emitted.
- Single word `32'h44332211` accepted at cycle N → bytes 11, 22, 33, 44 with K=0 on N+1..N+4; BC with K=1 at N+5; `o_Ready`=1 at N+4 and N+5.
- `COMMA_INTERVAL`=2 with `i_Valid` held high and 3 words → 8 back-to-back data bytes, 1 BC cycle (accepting word 3), then 4 data bytes; `o_Ready` is low at byte 3 of word 2.
- RD tracking: `i_Enc_Unbal`=1 on 3 valid cycles → `o_Enc_RD` goes 11, 01, 11, 01 on successive cycles. `i_Enc_Unbal`=1 while in OFF → RD stays 11.
- `i_Link_En` dropped during byte 1 of a word → next cycle `o_Enc_Valid`=0, `o_State`=00, RD=11, `o_Ready`=0. Re-enable → full 4-comma SYNC, and the old word is never emitted.
- `i_Rst_L`=0 in DATA at byte 2 with `i_Link_En`=1 → next cycle all outputs hold reset values. Release → SYNC restarts from count 0.
